// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmit path:
//   - ps2_state_t   : transmitter FSM states
//   - ERR_*         : err_code values reported by ps2_host_tx
//   - DEF_*_CYCLES  : default timing constants for a 50 MHz system clock
//   - CMD_*         : common keyboard command bytes
//   - odd_parity()  : PS/2 frame parity bit for a data byte
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NOACK   = 2'd2;

    // 50 MHz: 100 us inhibit, 5 us setup, 15 ms per-edge timeout
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_SETUP_CYCLES   = 250;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int DEF_FILTER_CYCLES  = 8;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    // Parity bit that makes the total number of ones in data+parity odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pin for use in the system clock domain: a 2-flop
// synchronizer followed by a debounce that only changes the filtered level
// after FILTER_CYCLES consecutive samples disagree with it.
//   clk, rst_n : system clock, asynchronous active-low reset
//   line_in    : raw pin level
//   level      : filtered level (resets to 1, the idle bus level)
//   fall       : one-cycle pulse in the cycle level changes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            fall    <= 1'b0;
            cnt     <= '0;
        end else begin
            // stage p0/p1: metastability synchronizer
            sync_p0 <= line_in;
            sync_p1 <= sync_p0;
            // debounce stage: any sample equal to the current level restarts
            // the run, so a glitch shorter than FILTER_CYCLES never lands
            fall <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                level <= sync_p1;
                fall  <= ~sync_p1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device command transmitter. Pulls the clock low to inhibit
// the device, issues the request-to-send start bit, then shifts out 8 data
// bits LSB first, odd parity and stop on device-generated falling clock
// edges, and finally checks the device's ack bit. Lines are driven
// open-drain: an *_oe of 1 means "pull low", the top level tri-states
// otherwise.
//   clk, rst_n             : system clock, asynchronous active-low reset
//   tx_data, tx_valid      : command byte and request
//   tx_ready               : high only while idle (accept = valid && ready)
//   ps2_clk_in, ps2_dat_in : raw pin levels
//   ps2_clk_oe, ps2_dat_oe : open-drain pull-low enables
//   busy                   : command in flight, receiver should hold off
//   tx_done, tx_err        : one-cycle completion / failure pulses
//   err_code               : ERR_* of the last command, held until next accept
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    // One timer serves the inhibit, setup and per-edge timeout phases, so it
    // is sized for the largest of the three.
    localparam int TMR_MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > TIMEOUT_CYCLES) ? TMR_MAX_A : TIMEOUT_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    ps2_state_t       state;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             parity;

    logic clk_lvl;
    logic clk_fall;
    logic dat_lvl;
    logic dat_fall_unused;
    logic accept;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_dat_in),
        .level   (dat_lvl),
        .fall    (dat_fall_unused)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    // Frame payload needs no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift  <= tx_data;
            parity <= odd_parity(tx_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            err_code   <= ERR_NONE;
            bit_idx    <= '0;
            timer      <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        err_code   <= ERR_NONE;
                        ps2_clk_oe <= 1'b1;
                        timer      <= '0;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (timer == TMR_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_dat_oe <= 1'b1;          // start bit
                        timer      <= '0;
                        state      <= REQ;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                REQ: begin
                    if (timer == TMR_W'(SETUP_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;          // hand the clock to the device
                        bit_idx    <= '0;
                        timer      <= '0;
                        state      <= DATA;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                DATA, PARITY, STOP, ACK, WAIT_IDLE: begin
                    // A device edge takes priority over a timeout in the same cycle.
                    if (clk_fall) begin
                        timer <= '0;
                        case (state)
                            DATA: begin
                                ps2_dat_oe <= ~shift[bit_idx];
                                if (bit_idx == 3'd7) begin
                                    state <= PARITY;
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
                            PARITY: begin
                                ps2_dat_oe <= ~parity;
                                state      <= STOP;
                            end
                            STOP: begin
                                ps2_dat_oe <= 1'b0;
                                state      <= ACK;
                            end
                            ACK: begin
                                if (!dat_lvl) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    ps2_clk_oe <= 1'b0;
                                    ps2_dat_oe <= 1'b0;
                                    tx_err     <= 1'b1;
                                    err_code   <= ERR_NOACK;
                                    state      <= IDLE;
                                end
                            end
                            default: begin
                                // WAIT_IDLE: extra edge only restarts the timeout
                            end
                        endcase
                    end else if (state == WAIT_IDLE && clk_lvl && dat_lvl) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        err_code   <= ERR_TIMEOUT;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Acts as the transmit counterpart to the existing keyboard receive path and shares the bidirectional PS2_CLK/PS2_DAT pins with it.
- Drives the lines open-drain through output-enable signals and runs the full request/clock/ack sequence.
- Reports completion or error; `busy` tells the receiver to hold off while a command is in flight.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time (100 us at 50 MHz).
- SETUP_CYCLES, 250: data-low-before-clock-release time (5 us).
- TIMEOUT_CYCLES, 750000: maximum wait for any device clock edge (15 ms).
- FILTER_CYCLES, 8: consecutive equal samples needed to accept a line level.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; top level drives 1'bz otherwise.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse on successful ack.
- tx_err  out  1  one-cycle pulse on failure.
- err_code  out  2  0 none, 1 timeout, 2 no-ack; held until next accept.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0; tx_done=0, tx_err=0, err_code=0; bit counter and timers 0.
  - Both lines are released immediately, including mid-transfer.
  - tx_ready=1 and busy=0 (decoded from state).
- Inputs: each pin goes through a 2-flop synchronizer, then a debounce that updates the filtered level only after FILTER_CYCLES equal samples. A falling edge is filtered 1 -> 0. Glitches shorter than FILTER_CYCLES are ignored.
- Byte capture: on accept, tx_data is latched, parity = ~^tx_data (odd), err_code cleared. tx_valid outside IDLE is ignored.
- States and transitions:
  - IDLE -> INHIBIT on accept. ps2_clk_oe=1 from the cycle after accept.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles -> REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit 0) for SETUP_CYCLES cycles. Then clk_oe=0 -> DATA, bit index=0, timeout counter cleared.
  - DATA: on each filtered clock falling edge, dat_oe = ~shift[bit index], LSB first. After the 8th edge -> PARITY.
  - PARITY: on the next falling edge, dat_oe = ~parity -> STOP.
  - STOP: on the next falling edge, dat_oe=0 (release, stop=1) -> ACK.
  - ACK: on the next falling edge (11th), sample filtered data. 0 -> WAIT_IDLE; 1 -> error 2.
  - WAIT_IDLE: wait until filtered clk=1 and dat=1, then pulse tx_done -> IDLE.
- Timeout: in DATA through WAIT_IDLE the counter clears on every filtered falling edge. Reaching TIMEOUT_CYCLES gives error 1.
- Error handling: clk_oe=0, dat_oe=0, tx_err pulse, err_code set, -> IDLE in the same cycle.
- Simultaneous events: a falling edge and a timeout in the same cycle means the edge wins. Done/err pulses never overlap, and tx_ready returns in the cycle after the pulse.
- Counter widths: each counter is wide enough for its parameter (clog2); no wrap-around is possible.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE);
  - ERR_NONE/ERR_TIMEOUT/ERR_NOACK;
  - default timing constants;
  - command byte constants (CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF).
- One sub-module, ps2_line_filter (synchronizer + debounce + fall-edge output), instantiated twice (clk, dat).

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and acks. Required:
  - clk_oe held 5000 cycles, start bit 0;
  - bits sampled on rising edges 1,0,1,1,0,1,1,1; parity 1; stop 1;
  - tx_done single pulse, err_code=0.
- Parity sweep: 0x00 -> parity 1, 0x01 -> parity 0, 0xFF -> parity 1, 0xF4 -> parity 0, each with tx_done.
- Device never clocks after release -> tx_err exactly TIMEOUT_CYCLES (+filter latency) after clk_oe falls; err_code=1; both oe=0; tx_ready=1.
- Device model leaves data high at the 11th edge -> tx_err, err_code=2, lines released.
- Assert rst_n low in DATA after bit 3 -> clk_oe=dat_oe=0 in the same cycle (async). After release tx_ready=1, and a new 0xF4 request completes normally.
- Protocol robustness:
  - tx_valid held during a transfer with 0x11 -> ignored; only the original byte is sent.
  - A 4-cycle glitch low on PS2_CLK during DATA -> no bit advance.
